udp_rx: RTL and testbench
=========================

Name: udp_rx

Overview:
- UDP receive layer. Sits between the IPv4 RX layer and the UDP RX user side, in the opposite direction to the UDP TX path.
- Takes an IPv4 payload byte stream plus IP header and parses the 8-byte UDP header.
- Presents the UDP header with a one-cycle udp_rx_start pulse, then forwards payload bytes with valid/last.
- Drops non-UDP packets and malformed datagrams, and counts the errors.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter
PORT_FILTER_EN, 0, 1 = drop datagrams whose dst_port != filter_port

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
ip_rx_start  input  1  one-cycle pulse; ip_rx.hdr is valid in this cycle
ip_rx  input  ipv4_rx_type  IP header {is_valid, protocol[7:0], data_length[15:0], src_ip_addr[31:0], is_broadcast} plus data {data_in[7:0], data_in_valid, data_in_last}
filter_port  input  16  local port, used only when PORT_FILTER_EN=1
udp_rx_start  output  1  one-cycle pulse; udp_rxi.hdr is valid from this cycle
udp_rxi  output  udp_rx_type  hdr {is_valid, src_ip_addr[31:0], src_port[15:0], dst_port[15:0], data_length[15:0]} plus data {data_in[7:0], data_in_valid, data_in_last}
udp_rx_result  output  2  00 idle, 01 receiving, 10 done ok, 11 error
rx_err_count  output  ERR_CNT_W  saturating count of dropped datagrams

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE.
  - All outputs 0, including hdr fields, data_in_valid, data_in_last, udp_rx_result=00 and rx_err_count=0.
  - Byte counter cleared. A datagram in flight is abandoned with no last emitted.
- No backpressure. ip_rx data is consumed every cycle it is valid.
- State machine IDLE -> HDR -> PAYLOAD -> IDLE, with DISCARD as a side branch.
- IDLE:
  - Waits for ip_rx_start. Latches src_ip_addr and ip data_length.
  - protocol==8'h11 and is_valid=1 -> HDR, result=01. Otherwise -> DISCARD (no error count).
- HDR:
  - 16-bit byte counter increments on each data_in_valid.
  - Bytes 0-1 = src_port, 2-3 = dst_port, 4-5 = length, 6-7 = checksum (ignored). All fields are big-endian.
  - After byte 7 is sampled, the header is checked:
    - length<8, length>ip data_length, or filter mismatch -> DISCARD, err++, result=11.
    - Otherwise udp_rx_start=1 on the next cycle with hdr.is_valid=1 and data_length=length-8, then -> PAYLOAD.
  - hdr fields hold until the next accepted datagram or reset.
- HDR, data_in_last seen before byte 7 -> IDLE, err++, result=11, no start pulse.
- PAYLOAD:
  - Each valid input byte appears on udp_rxi.data exactly 1 cycle later (registered).
  - data_in_last is asserted with byte number data_length-1.
  - Bytes beyond data_length (Ethernet padding) are not forwarded; go to DISCARD if the IP last has not yet arrived. If the last byte coincides with the IP data_in_last -> IDLE.
  - IP data_in_last arrives before data_length bytes -> forward that byte with data_in_last=1, err++, result=11.
  - Clean completion -> result=10.
- data_length==0 (length==8): start pulse issued, no payload bytes, result=10.
- DISCARD: swallow input until data_in_last, then -> IDLE. No outputs toggle.
- ip_rx_start while not in IDLE: abort the current datagram. If it was in PAYLOAD, assert data_in_last on the output the next cycle with data_in_valid=0; err++. Then process the new start as if in IDLE, in the same cycle.
- rx_err_count saturates at all-ones.
- result holds 10/11 until the next ip_rx_start.

Decomposition:
- global_typs_pkg holds ipv4_rx_type, udp_rx_type, udp_rx_header_type, the constant UDP_PROTOCOL=8'h11, UDP_HDR_LEN=8, and the result-code constants.
- No sub-module. A single FSM plus byte counter is the natural structure.

Test Plan:
1. UDP datagram, src_port 0x1234, dst_port 0x5678, length 0x000C, 4 payload bytes AA BB CC DD -> one start pulse with hdr {0x1234, 0x5678, data_length 4}; bytes AA BB CC DD each 1 cycle after input; last on DD; result=10.
2. protocol 8'h06 (TCP), 20 bytes -> no start, no data_valid, rx_err_count=0.
3. length=0x000A, 6 payload bytes, ip data_length=14 -> 2 bytes forwarded, last on byte 2, last 4 bytes dropped, result=10.
4. ip data_in_last at header byte 5 -> no start, result=11, rx_err_count=1. Repeat 300 times with ERR_CNT_W=8 -> count saturates at 255.
5. length=0x0008 -> start with data_length 0, no data bytes, result=10.
6. Reset asserted mid-payload after 2 of 4 bytes -> next cycle all outputs 0, state IDLE. The next datagram from test 1 is received correctly.

Source files
------------

// File: rtl/global_typs_pkg.sv
// Shared stream and header types for the IPv4/UDP receive path, plus the
// UDP constants and result codes used by udp_rx.
package global_typs_pkg;

   localparam logic [7:0]  UDP_PROTOCOL = 8'h11;
   localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

   localparam logic [1:0] UDP_RES_IDLE = 2'b00;
   localparam logic [1:0] UDP_RES_RX   = 2'b01;
   localparam logic [1:0] UDP_RES_OK   = 2'b10;
   localparam logic [1:0] UDP_RES_ERR  = 2'b11;

   typedef struct packed {
      logic [7:0] data_in;
      logic       data_in_valid;
      logic       data_in_last;
   } rx_data_type;

   typedef struct packed {
      logic        is_valid;
      logic [7:0]  protocol;
      logic [15:0] data_length;
      logic [31:0] src_ip_addr;
      logic        is_broadcast;
   } ipv4_rx_header_type;

   typedef struct packed {
      ipv4_rx_header_type hdr;
      rx_data_type        data;
   } ipv4_rx_type;

   typedef struct packed {
      logic        is_valid;
      logic [31:0] src_ip_addr;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] data_length;
   } udp_rx_header_type;

   typedef struct packed {
      udp_rx_header_type hdr;
      rx_data_type       data;
   } udp_rx_type;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_DISCARD
   } udp_rx_state_t;

endpackage

// File: rtl/udp_rx.sv
// UDP receive layer: parses the 8-byte UDP header out of the IPv4 payload
// stream, announces it with a one-cycle start pulse, forwards the payload
// one cycle later, and drops/counts malformed datagrams.
module udp_rx
   import global_typs_pkg::*;
#(
   parameter int ERR_CNT_W      = 8,
   parameter bit PORT_FILTER_EN = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ip_rx_start,
   input  ipv4_rx_type          ip_rx,
   input  logic [15:0]          filter_port,
   output logic                 udp_rx_start,
   output udp_rx_type           udp_rxi,
   output logic [1:0]           udp_rx_result,
   output logic [ERR_CNT_W-1:0] rx_err_count
);

   udp_rx_state_t state;
   logic [15:0]   byte_cnt;
   logic [15:0]   ip_len_r;
   logic [31:0]   src_ip_r;
   logic [15:0]   src_port_r;
   logic [15:0]   dst_port_r;
   logic [15:0]   len_r;

   logic          is_udp;
   logic          in_vld;
   logic          in_last;
   logic [7:0]    in_byte;
   logic          hdr_bad;
   logic          pay_end;
   logic          abort_err;
   logic          unused_ip_bits;

   // Saturating increment for the error counter.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign in_vld    = ip_rx.data.data_in_valid;
   assign in_last   = ip_rx.data.data_in_last;
   assign in_byte   = ip_rx.data.data_in;
   assign is_udp    = ip_rx.hdr.is_valid && (ip_rx.hdr.protocol == UDP_PROTOCOL);
   // Header check runs on the byte-7 cycle; length/port bytes are already latched.
   assign hdr_bad   = (len_r < UDP_HDR_LEN) || (len_r > ip_len_r) ||
                      (PORT_FILTER_EN && (dst_port_r != filter_port));
   assign pay_end   = (byte_cnt == (udp_rxi.hdr.data_length - 16'd1));
   // A start arriving mid-datagram abandons a datagram that was still live.
   assign abort_err = (state == ST_HDR) || (state == ST_PAYLOAD);
   // Broadcast flag has no role at the UDP layer.
   assign unused_ip_bits = ip_rx.hdr.is_broadcast;

   // Receive FSM: header parse, payload forwarding, discard and error counting.
   always_ff @(posedge clk) begin
      udp_rx_start               <= 1'b0;
      udp_rxi.data.data_in_valid <= 1'b0;
      udp_rxi.data.data_in_last  <= 1'b0;
      if (reset) begin
         state         <= ST_IDLE;
         byte_cnt      <= '0;
         ip_len_r      <= '0;
         src_ip_r      <= '0;
         src_port_r    <= '0;
         dst_port_r    <= '0;
         len_r         <= '0;
         udp_rxi       <= '0;
         udp_rx_result <= UDP_RES_IDLE;
         rx_err_count  <= '0;
      end else if (ip_rx_start) begin
         // Abandon anything in flight; a live payload gets a bare last marker.
         if (state == ST_PAYLOAD) begin
            udp_rxi.data.data_in_last <= 1'b1;
         end
         if (abort_err || (is_udp && in_vld && in_last)) begin
            rx_err_count <= sat_inc(rx_err_count);
         end
         ip_len_r <= ip_rx.hdr.data_length;
         src_ip_r <= ip_rx.hdr.src_ip_addr;
         byte_cnt <= '0;
         if (is_udp) begin
            state         <= ST_HDR;
            udp_rx_result <= UDP_RES_RX;
            // A byte travelling with the start pulse is header byte 0.
            if (in_vld) begin
               src_port_r[15:8] <= in_byte;
               byte_cnt         <= 16'd1;
               if (in_last) begin
                  state         <= ST_IDLE;
                  udp_rx_result <= UDP_RES_ERR;
               end
            end
         end else begin
            udp_rx_result <= UDP_RES_IDLE;
            state         <= (in_vld && in_last) ? ST_IDLE : ST_DISCARD;
         end
      end else begin
         case (state)
            ST_HDR: begin
               if (in_vld) begin
                  byte_cnt <= byte_cnt + 16'd1;
                  case (byte_cnt[2:0])
                     3'd0:    src_port_r[15:8] <= in_byte;
                     3'd1:    src_port_r[7:0]  <= in_byte;
                     3'd2:    dst_port_r[15:8] <= in_byte;
                     3'd3:    dst_port_r[7:0]  <= in_byte;
                     3'd4:    len_r[15:8]      <= in_byte;
                     3'd5:    len_r[7:0]       <= in_byte;
                     default: ;
                  endcase
                  if (byte_cnt[2:0] == 3'd7) begin
                     byte_cnt <= '0;
                     if (hdr_bad || (in_last && (len_r != UDP_HDR_LEN))) begin
                        rx_err_count  <= sat_inc(rx_err_count);
                        udp_rx_result <= UDP_RES_ERR;
                        state         <= in_last ? ST_IDLE : ST_DISCARD;
                     end else begin
                        udp_rx_start            <= 1'b1;
                        udp_rxi.hdr.is_valid    <= 1'b1;
                        udp_rxi.hdr.src_ip_addr <= src_ip_r;
                        udp_rxi.hdr.src_port    <= src_port_r;
                        udp_rxi.hdr.dst_port    <= dst_port_r;
                        udp_rxi.hdr.data_length <= len_r - UDP_HDR_LEN;
                        if (len_r == UDP_HDR_LEN) begin
                           udp_rx_result <= UDP_RES_OK;
                           state         <= in_last ? ST_IDLE : ST_DISCARD;
                        end else begin
                           state <= ST_PAYLOAD;
                        end
                     end
                  end else if (in_last) begin
                     rx_err_count  <= sat_inc(rx_err_count);
                     udp_rx_result <= UDP_RES_ERR;
                     state         <= ST_IDLE;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (in_vld) begin
                  udp_rxi.data.data_in       <= in_byte;
                  udp_rxi.data.data_in_valid <= 1'b1;
                  byte_cnt                   <= byte_cnt + 16'd1;
                  if (pay_end) begin
                     udp_rxi.data.data_in_last <= 1'b1;
                     udp_rx_result             <= UDP_RES_OK;
                     state                     <= in_last ? ST_IDLE : ST_DISCARD;
                  end else if (in_last) begin
                     udp_rxi.data.data_in_last <= 1'b1;
                     rx_err_count              <= sat_inc(rx_err_count);
                     udp_rx_result             <= UDP_RES_ERR;
                     state                     <= ST_IDLE;
                  end
               end
            end
            ST_DISCARD: begin
               if (in_vld && in_last) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_rx.sv
// Bench for udp_rx: table of datagram vectors with a byte scoreboard, plus
// hand-written abort, saturation and mid-payload reset sequences.
module tb_udp_rx;
   import global_typs_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ip_rx_start;
   ipv4_rx_type ip_rx;
   logic [15:0] filter_port;
   logic        udp_rx_start;
   udp_rx_type  udp_rxi;
   logic [1:0]  udp_rx_result;
   logic [7:0]  rx_err_count;

   always #5 clk = ~clk;

   udp_rx #(.ERR_CNT_W(8), .PORT_FILTER_EN(1'b0)) dut (
      .clk           (clk),
      .reset         (reset),
      .ip_rx_start   (ip_rx_start),
      .ip_rx         (ip_rx),
      .filter_port   (filter_port),
      .udp_rx_start  (udp_rx_start),
      .udp_rxi       (udp_rxi),
      .udp_rx_result (udp_rx_result),
      .rx_err_count  (rx_err_count)
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         cyc;
   } exp_byte_t;

   typedef struct {
      logic        vld;
      logic [7:0]  proto;
      logic [15:0] sp;
      logic [15:0] dp;
      logic [15:0] ulen;
      logic [15:0] iplen;
      int          npay;
      int          hlast;
      int          exp_starts;
      logic [15:0] exp_dlen;
      logic [1:0]  exp_res;
      int          exp_err_inc;
   } vec_t;

   exp_byte_t   sb[$];
   vec_t        vt[9];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          starts = 0;
   int          aborts = 0;
   int          exp_err = 0;
   logic [15:0] exp_sp = 16'h0;
   logic [15:0] exp_dp = 16'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: counts start pulses and bare last markers, checks bytes.
   always @(negedge clk) begin
      exp_byte_t e;
      if (udp_rx_start) starts <= starts + 1;
      if (udp_rxi.data.data_in_valid) begin
         if (sb.size() == 0) begin
            chk("extra_byte", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("byte_data", udp_rxi.data.data_in, e.data);
            chk("byte_last", udp_rxi.data.data_in_last, e.last);
            chk("byte_cycle", cyc, e.cyc);
         end
      end else if (udp_rxi.data.data_in_last) begin
         aborts <= aborts + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one IP packet; stop_after>=0 cuts it short with no IP last.
   task automatic send_dgram(input logic vld, input logic [7:0] proto,
                             input logic [15:0] sp, input logic [15:0] dp,
                             input logic [15:0] ulen, input logic [15:0] iplen,
                             input int npay, input int hlast, input int stop_after);
      logic [7:0] bytes[$];
      int         n;
      int         dlen;
      logic       final_last;
      logic       accept;
      exp_byte_t  e;
      bytes.push_back(sp[15:8]);   bytes.push_back(sp[7:0]);
      bytes.push_back(dp[15:8]);   bytes.push_back(dp[7:0]);
      bytes.push_back(ulen[15:8]); bytes.push_back(ulen[7:0]);
      bytes.push_back(8'h00);      bytes.push_back(8'h00);
      for (int i = 0; i < npay; i++) bytes.push_back(8'hAA + 8'(17 * i));
      n = bytes.size();
      if (hlast >= 0) n = hlast + 1;
      if (stop_after >= 0) n = stop_after;
      final_last = (stop_after < 0);
      dlen = int'(ulen) - 8;
      accept = vld && (proto == 8'h11) && (n >= 8) && (ulen >= 16'd8) &&
               (ulen <= iplen) && !(n == 8 && final_last && ulen != 16'd8);
      if (accept) begin
         exp_sp = sp;
         exp_dp = dp;
      end
      ip_rx.hdr.is_valid     = vld;
      ip_rx.hdr.protocol     = proto;
      ip_rx.hdr.data_length  = iplen;
      ip_rx.hdr.src_ip_addr  = 32'hC0A8_0105;
      ip_rx.hdr.is_broadcast = 1'b0;
      ip_rx_start = 1'b1;
      tick();
      ip_rx_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         logic lst;
         lst = final_last && (i == n - 1);
         ip_rx.data.data_in       = bytes[i];
         ip_rx.data.data_in_valid = 1'b1;
         ip_rx.data.data_in_last  = lst;
         if (accept && i >= 8 && (i - 8) < dlen) begin
            e.data = bytes[i];
            e.last = lst || ((i - 8) == dlen - 1);
            e.cyc  = cyc + 1;
            sb.push_back(e);
         end
         tick();
      end
      ip_rx.data.data_in_valid = 1'b0;
      ip_rx.data.data_in_last  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s0;
      int a0;
      vt[0] = '{1'b1, 8'h11, 16'h1234, 16'h5678, 16'h000C, 16'd12, 4, -1, 1, 16'd4, 2'b10, 0};
      vt[1] = '{1'b1, 8'h06, 16'h0050, 16'h1F90, 16'h0014, 16'd20, 12, -1, 0, 16'd4, 2'b00, 0};
      vt[2] = '{1'b1, 8'h11, 16'h0400, 16'h0401, 16'h000A, 16'd14, 6, -1, 1, 16'd2, 2'b10, 0};
      vt[3] = '{1'b1, 8'h11, 16'h1111, 16'h2222, 16'h0008, 16'd8, 0, -1, 1, 16'd0, 2'b10, 0};
      vt[4] = '{1'b1, 8'h11, 16'h3333, 16'h4444, 16'h0006, 16'd12, 4, -1, 0, 16'd0, 2'b11, 1};
      vt[5] = '{1'b1, 8'h11, 16'h5555, 16'h6666, 16'h0014, 16'd12, 4, -1, 0, 16'd0, 2'b11, 1};
      vt[6] = '{1'b1, 8'h11, 16'h7777, 16'h8888, 16'h0010, 16'd16, 3, -1, 1, 16'd8, 2'b11, 1};
      vt[7] = '{1'b0, 8'h11, 16'h9999, 16'hAAAA, 16'h000C, 16'd12, 4, -1, 0, 16'd8, 2'b00, 0};
      vt[8] = '{1'b1, 8'h11, 16'hBBBB, 16'hCCCC, 16'h000C, 16'd12, 4, 5, 0, 16'd8, 2'b11, 1};

      reset       = 1'b1;
      ip_rx_start = 1'b0;
      ip_rx       = '0;
      filter_port = 16'h5678;
      repeat (3) tick();
      chk("rst_udp_rxi", udp_rxi, 0);
      chk("rst_start", udp_rx_start, 0);
      chk("rst_result", udp_rx_result, 0);
      chk("rst_err", rx_err_count, 0);
      reset = 1'b0;
      tick();

      for (int k = 0; k < 9; k++) begin
         s0 = starts;
         send_dgram(vt[k].vld, vt[k].proto, vt[k].sp, vt[k].dp, vt[k].ulen,
                    vt[k].iplen, vt[k].npay, vt[k].hlast, -1);
         repeat (3) tick();
         exp_err += vt[k].exp_err_inc;
         chk($sformatf("v%0d_starts", k), starts - s0, vt[k].exp_starts);
         chk($sformatf("v%0d_dlen", k), udp_rxi.hdr.data_length, vt[k].exp_dlen);
         chk($sformatf("v%0d_sport", k), udp_rxi.hdr.src_port, exp_sp);
         chk($sformatf("v%0d_dport", k), udp_rxi.hdr.dst_port, exp_dp);
         chk($sformatf("v%0d_result", k), udp_rx_result, vt[k].exp_res);
         chk($sformatf("v%0d_err", k), rx_err_count, exp_err);
         chk($sformatf("v%0d_sb_empty", k), sb.size(), 0);
      end
      chk("hdr_src_ip", udp_rxi.hdr.src_ip_addr, 32'hC0A8_0105);
      chk("hdr_is_valid", udp_rxi.hdr.is_valid, 1);

      // New start while payload is live: bare last marker, one error, new datagram ok.
      s0 = starts;
      a0 = aborts;
      send_dgram(1'b1, 8'h11, 16'h1234, 16'h5678, 16'h000C, 16'd12, 4, -1, 10);
      send_dgram(1'b1, 8'h11, 16'h1234, 16'h5678, 16'h000C, 16'd12, 4, -1, -1);
      repeat (3) tick();
      exp_err++;
      chk("abort_marker", aborts - a0, 1);
      chk("abort_starts", starts - s0, 2);
      chk("abort_err", rx_err_count, exp_err);
      chk("abort_result", udp_rx_result, 2'b10);
      chk("abort_sb_empty", sb.size(), 0);

      // Error counter saturation.
      for (int r = 0; r < 300; r++) begin
         send_dgram(1'b1, 8'h11, 16'hBBBB, 16'hCCCC, 16'h000C, 16'd12, 4, 5, -1);
         if (exp_err < 255) exp_err++;
      end
      repeat (2) tick();
      chk("sat_err", rx_err_count, exp_err);
      chk("sat_result", udp_rx_result, 2'b11);

      // Reset after 2 of 4 payload bytes, then a clean datagram.
      send_dgram(1'b1, 8'h11, 16'h1234, 16'h5678, 16'h000C, 16'd12, 4, -1, 10);
      reset = 1'b1;
      tick();
      chk("midrst_udp_rxi", udp_rxi, 0);
      chk("midrst_start", udp_rx_start, 0);
      chk("midrst_result", udp_rx_result, 0);
      chk("midrst_err", rx_err_count, 0);
      chk("midrst_sb_empty", sb.size(), 0);
      reset = 1'b0;
      tick();
      s0 = starts;
      send_dgram(1'b1, 8'h11, 16'h1234, 16'h5678, 16'h000C, 16'd12, 4, -1, -1);
      repeat (3) tick();
      chk("post_starts", starts - s0, 1);
      chk("post_dlen", udp_rxi.hdr.data_length, 16'd4);
      chk("post_sport", udp_rxi.hdr.src_port, 16'h1234);
      chk("post_result", udp_rx_result, 2'b10);
      chk("post_err", rx_err_count, 0);
      chk("post_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
